// File: rtl/rx_sync_pkg.sv
// Shared definitions for the N-channel receive FIFO: default symbols,
// sync FSM state encoding and a width helper.
package rx_sync_pkg;

  localparam logic [9:0] COMMA_DEF = 10'h0BC;
  localparam logic [9:0] IDLE_DEF  = 10'h07C;

  typedef enum logic {
    SEARCH = 1'b0,
    SYNCED = 1'b1
  } sync_state_t;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/rx_sync_fifo_nch_if.sv
// Receive-side bus of the N-channel FIFO: code word, per-channel strobes,
// read data and per-channel status.
interface rx_sync_fifo_nch_if #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int NUM_CH    = 2
);
  logic [DATA_SIZE-1:0]        in;
  logic [NUM_CH-1:0]           write;
  logic [NUM_CH-1:0]           read;
  logic [NUM_CH*MAIN_SIZE-1:0] out;
  logic [NUM_CH-1:0]           valid;
  logic                        active;
  logic [NUM_CH-1:0]           full;
  logic [NUM_CH-1:0]           empty;
  logic [NUM_CH-1:0]           overflow;
  logic [NUM_CH-1:0]           underflow;

  modport master (
    output in, write, read,
    input  out, valid, active, full, empty, overflow, underflow
  );

  modport slave (
    input  in, write, read,
    output out, valid, active, full, empty, overflow, underflow
  );
endinterface

// File: rtl/rx_sync_fifo_nch_fifo.sv
// Single-clock payload FIFO with registered read data, registered full/empty
// and sticky overflow/underflow flags.
module sync_fifo
  import rx_sync_pkg::*;
#(
  parameter int MAIN_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [MAIN_SIZE-1:0] din,
  output logic [MAIN_SIZE-1:0] dout,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [MAIN_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 do_rd;
  logic                 do_wr;

  // A read frees a slot in the same edge, so a full FIFO still accepts a write.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      dout      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(FIFO_DEPTH));
      empty <= (count_next == '0);
      valid <= do_rd;
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_rd) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_sync_fifo_nch.sv
// N-channel receive buffer: comma-count link sync, comma/idle stripping and
// per-channel payload FIFOs.
module rx_sync_fifo_nch
  import rx_sync_pkg::*;
#(
  parameter int                   DATA_SIZE  = 10,
  parameter int                   MAIN_SIZE  = 8,
  parameter int                   NUM_CH     = 2,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(COMMA_DEF),
  parameter logic [DATA_SIZE-1:0] IDLE       = DATA_SIZE'(IDLE_DEF),
  parameter int                   SYNC_COUNT = 4,
  parameter int                   LOSS_COUNT = 3
) (
  input logic               clk,
  input logic               reset,
  rx_sync_fifo_nch_if.slave bus
);

  localparam int SCW = clog2(SYNC_COUNT + 1);
  localparam int LCW = clog2(LOSS_COUNT + 1);

  sync_state_t state;
  sync_state_t state_next;
  logic [SCW-1:0] comma_cnt;
  logic [SCW-1:0] comma_cnt_next;
  logic [LCW-1:0] viol_cnt;
  logic [LCW-1:0] viol_cnt_next;
  logic           active_q;
  logic           is_comma;
  logic           is_idle;
  logic           is_violation;
  logic           data_word;

  logic [NUM_CH-1:0]           wr_qual;
  logic [NUM_CH*MAIN_SIZE-1:0] out_w;
  logic [NUM_CH-1:0]           valid_w;
  logic [NUM_CH-1:0]           full_w;
  logic [NUM_CH-1:0]           empty_w;
  logic [NUM_CH-1:0]           overflow_w;
  logic [NUM_CH-1:0]           underflow_w;

  assign is_comma     = (bus.in == COMMA);
  assign is_idle      = (bus.in == IDLE);
  assign is_violation = (bus.in[DATA_SIZE-1:MAIN_SIZE] != '0) && !is_comma && !is_idle;
  assign data_word    = (state == SYNCED) && !is_comma && !is_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      comma_cnt <= '0;
      viol_cnt  <= '0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_next;
      comma_cnt <= comma_cnt_next;
      viol_cnt  <= viol_cnt_next;
      active_q  <= (state_next == SYNCED);
    end
  end

  // Each state only counts its own run; the other counter is held at zero.
  always_comb begin
    state_next     = state;
    comma_cnt_next = '0;
    viol_cnt_next  = '0;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          if (comma_cnt == SCW'(SYNC_COUNT - 1)) begin
            state_next = SYNCED;
          end else begin
            comma_cnt_next = comma_cnt + SCW'(1);
          end
        end
      end
      SYNCED: begin
        if (is_violation) begin
          if (viol_cnt == LCW'(LOSS_COUNT - 1)) begin
            state_next = SEARCH;
          end else begin
            viol_cnt_next = viol_cnt + LCW'(1);
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign wr_qual = bus.write & {NUM_CH{data_word}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_fifo #(
      .MAIN_SIZE (MAIN_SIZE),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr_qual[i]),
      .rd       (bus.read[i]),
      .din      (bus.in[MAIN_SIZE-1:0]),
      .dout     (out_w[i*MAIN_SIZE +: MAIN_SIZE]),
      .valid    (valid_w[i]),
      .full     (full_w[i]),
      .empty    (empty_w[i]),
      .overflow (overflow_w[i]),
      .underflow(underflow_w[i])
    );
  end

  assign bus.out       = out_w;
  assign bus.valid     = valid_w;
  assign bus.active    = active_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_w;
  assign bus.underflow = underflow_w;

endmodule

// File: doc/rx_sync_fifo_nch.md
Name: rx_sync_fifo_nch

Overview:
- Parametrised N-channel receive buffer for the adaptive PCIe switching path; successor to the fixed two-FIFO 10-bit device.
- Receives DATA_SIZE-bit code words and gates traffic with a comma-count sync FSM.
- Strips comma and idle symbols, then writes MAIN_SIZE-bit payload into per-channel FIFOs under per-channel write/read strobes.
- Reports per-channel full, empty, overflow and underflow, plus a link-active flag.

Parameters:
- DATA_SIZE, 10, input code word width.
- MAIN_SIZE, 8, payload width (in[MAIN_SIZE-1:0]); must satisfy MAIN_SIZE < DATA_SIZE.
- NUM_CH, 2, number of channels/FIFOs, 1..8.
- FIFO_DEPTH, 4, entries per FIFO; power of two, >= 2.
- COMMA, 10'h0BC, full-width sync symbol.
- IDLE, 10'h07C, full-width idle symbol.
- SYNC_COUNT, 4, consecutive COMMAs needed to go active.
- LOSS_COUNT, 3, consecutive code violations that drop sync.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- in  in  DATA_SIZE  received code word.
- write  in  NUM_CH  per-channel write request.
- read  in  NUM_CH  per-channel read request.
- out  out  NUM_CH*MAIN_SIZE  registered read data; channel i occupies bits [i*MAIN_SIZE +: MAIN_SIZE].
- valid  out  NUM_CH  one-cycle pulse: out slice i updated this cycle.
- active  out  1  link synchronised.
- full  out  NUM_CH  FIFO i full.
- empty  out  NUM_CH  FIFO i empty.
- overflow  out  NUM_CH  sticky; write refused because FIFO i was full.
- underflow  out  NUM_CH  sticky; read requested while FIFO i was empty.

Behaviour:
- Reset values: out=0, valid=0, active=0, full=0, empty=all 1, overflow=0, underflow=0. All FIFO pointers and counters clear, and the FSM goes to SEARCH. A reset asserted mid-operation discards all FIFO contents immediately.
- FSM states are SEARCH and SYNCED.
  - SEARCH: comma counter increments when in==COMMA and clears on any other word. When the counter reaches SYNC_COUNT, the FSM enters SYNCED on that clock edge; active is registered high in the same edge (the 4th COMMA sampled -> active=1 on that edge).
  - SYNCED: a code violation is in[DATA_SIZE-1:MAIN_SIZE]!=0 with in not equal to COMMA or IDLE. The violation counter clears on any non-violating word. When the counter reaches LOSS_COUNT, the FSM returns to SEARCH and active=0. FIFO contents are retained.
- Data word: in is neither COMMA nor IDLE, and the FSM is in SYNCED.
- Write to channel i occurs when write[i] && data word && !full[i]. Stored value is in[MAIN_SIZE-1:0].
  - Multiple write bits set broadcast the word to every selected, non-full channel.
  - A write request with a non-data word, or while in SEARCH, is silently dropped with no error.
- Read of channel i occurs when read[i] && !empty[i]. out slice i <= head entry and valid[i]=1 on the next edge (1-cycle latency). out holds its last value otherwise.
- Overflow: write[i] with a data word while full[i] and no simultaneous read[i] sets overflow[i]. It is sticky until reset, and the word is dropped.
- Underflow: read[i] while empty[i] sets underflow[i]. It is sticky until reset; out and valid are unchanged.
- Simultaneous read and write on channel i:
  - Full: both are performed, count is unchanged, no overflow.
  - Empty: the read underflows and the write is performed. There is no bypass; data is readable next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits. full = (count==FIFO_DEPTH), empty = (count==0), both registered from the next-state count.

Decomposition:
- Shared package rx_sync_pkg holds:
  - COMMA and IDLE defaults;
  - state encoding (SEARCH=1'b0, SYNCED=1'b1);
  - a clog2 function for pointer and count widths.
- Sub-module sync_fifo (params MAIN_SIZE, FIFO_DEPTH; ports clk, reset, wr, rd, din, dout, valid, full, empty, overflow, underflow).
  - It is instantiated NUM_CH times in a generate loop.
  - The top holds the sync FSM and the write qualification.

Test Plan:
- Reset, then feed 3x 10'h0BC followed by 10'h0FF with write=2'b11 -> active stays 0, no FIFO write, empty=2'b11, no errors.
- Feed 4x 10'h0BC, then 10'h0FF with write=2'b01, then read=2'b01 -> active=1 after 4th BC. The next cycle after the read gives out[7:0]=8'hFF and valid=2'b01; empty[0] returns to 1.
- Synced; write 10'hEE, 10'hBB to ch1, then 10'h07C with write=2'b10 -> IDLE is dropped. Two reads return 8'hEE then 8'hBB.
- Synced, FIFO_DEPTH=4; write 5 data words to ch0 -> full[0]=1 after 4, overflow[0]=1 after 5th. Reads return the first 4 words in order; then a read on empty sets underflow[0]=1.
- Full ch0; read[0] and write[0] with 10'h011 together -> count stays 4, overflow[0]=0. Subsequent reads end with 8'h11.
- Synced; feed 3x 10'h3FF -> active drops to 0 and FIFO data is kept. Assert reset mid-stream -> all outputs return to reset values within the reset assertion.
